// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counting timer with one-shot/periodic modes and expiry tally
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load,
  output logic [WIDTH-1:0] count,
  output logic             tcount,
  output logic             busy,
  output logic             expired,
  output logic [7:0]       exp_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic [WIDTH-1:0] count_n;
  logic             expired_n;
  logic [7:0]       exp_cnt_n;

  logic load_nz;
  logic at_one;

  assign load_nz = (load != '0);
  assign at_one  = (count == WIDTH'(1));

  // State register and all registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      reload  <= '0;
      expired <= 1'b0;
      exp_cnt <= 8'd0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      reload  <= reload_n;
      expired <= expired_n;
      exp_cnt <= exp_cnt_n;
    end
  end

  // Next-state logic: abort beats retrigger beats counting, expiry happens on the 1->0 step.
  always_comb begin
    state_n   = state;
    count_n   = count;
    reload_n  = reload;
    expired_n = 1'b0;
    exp_cnt_n = exp_cnt;
    case (state)
      IDLE: begin
        if (!abort && start && load_nz) begin
          count_n  = load;
          reload_n = load;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (abort || (start && !load_nz)) begin
          count_n = '0;
          state_n = IDLE;
        end else if (start) begin
          count_n  = load;
          reload_n = load;
        end else if (en) begin
          if (at_one) begin
            expired_n = 1'b1;
            if (exp_cnt != 8'hff) begin
              exp_cnt_n = exp_cnt + 8'd1;
            end
            if (periodic) begin
              count_n = reload;
            end else begin
              count_n = '0;
              state_n = IDLE;
            end
          end else begin
            count_n = count - WIDTH'(1);
          end
        end
      end
      default: begin
        count_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Look-ahead: this edge will expire unless something of higher priority intervenes.
  assign tcount = (state == RUN) && at_one && en && !abort && !start;
  assign busy   = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - randomized and directed self-checking bench for countdown_timer
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic       abort;
  logic       periodic;
  logic [7:0] load;
  logic [7:0] count;
  logic       tcount;
  logic       busy;
  logic       expired;
  logic [7:0] exp_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  // reference model state
  bit m_run;
  int m_count;
  int m_reload;
  bit m_exp;
  int m_tally;

  int pulses;

  countdown_timer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .abort    (abort),
    .periodic (periodic),
    .load     (load),
    .count    (count),
    .tcount   (tcount),
    .busy     (busy),
    .expired  (expired),
    .exp_cnt  (exp_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check look-ahead, clock, update model, check registered outputs.
  task automatic cyc(input bit r, input bit st, input bit ab, input bit e,
                     input bit per, input int ld);
    bit exp_tc;
    @(negedge clk);
    rst = r; start = st; abort = ab; en = e; periodic = per; load = 8'(ld);
    #1;
    exp_tc = m_run && (m_count == 1) && e && !ab && !st;
    check("tcount", int'(tcount), int'(exp_tc));
    @(posedge clk);
    #1;
    if (r) begin
      m_run = 0; m_count = 0; m_reload = 0; m_exp = 0; m_tally = 0;
    end else begin
      m_exp = 0;
      if (!m_run) begin
        if (!ab && st && ld != 0) begin
          m_count = ld; m_reload = ld; m_run = 1;
        end
      end else if (ab || (st && ld == 0)) begin
        m_count = 0; m_run = 0;
      end else if (st) begin
        m_count = ld; m_reload = ld;
      end else if (e) begin
        if (m_count == 1) begin
          m_exp = 1;
          m_tally = (m_tally < 255) ? m_tally + 1 : 255;
          if (per) m_count = m_reload;
          else begin
            m_count = 0; m_run = 0;
          end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
    check("count", int'(count), m_count);
    check("busy", int'(busy), int'(m_run));
    check("expired", int'(expired), int'(m_exp));
    check("exp_cnt", int'(exp_cnt), m_tally);
    if (expired) pulses++;
  endtask

  initial begin
    rst = 1'b1; start = 0; abort = 0; en = 0; periodic = 0; load = 0;
    m_run = 0; m_count = 0; m_reload = 0; m_exp = 0; m_tally = 0;

    // reset state
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(count), 0);

    // one-shot load 3
    cyc(0, 1, 0, 1, 0, 3);
    pulses = 0;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
    check("oneshot_pulses", pulses, 1);
    check("oneshot_tally", int'(exp_cnt), 1);
    check("oneshot_busy", int'(busy), 0);

    // periodic load 2
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 1, 2);
    pulses = 0;
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 1, 0);
    check("periodic_pulses", pulses, 3);
    check("periodic_tally", int'(exp_cnt), 3);
    check("periodic_busy", int'(busy), 1);

    // load 4 with en toggling
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 4);
    pulses = 0;
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, (i % 2) == 0, 0, 0);
    check("toggle_pulses", pulses, 1);
    check("toggle_count", int'(count), 0);

    // retrigger then abort
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 5);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("pre_retrig_count", int'(count), 2);
    pulses = 0;
    cyc(0, 1, 0, 1, 0, 7);
    check("retrig_count", int'(count), 7);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 0);
    check("pre_abort_count", int'(count), 3);
    cyc(0, 0, 1, 1, 0, 0);
    check("abort_busy", int'(busy), 0);
    check("abort_pulses", pulses, 0);
    check("abort_tally", int'(exp_cnt), 0);

    // load 0 ignored in idle
    cyc(0, 1, 0, 1, 0, 0);
    check("zero_load_busy", int'(busy), 0);

    // saturation with load 1 periodic
    cyc(0, 1, 0, 1, 1, 1);
    for (int i = 0; i < 258; i++) cyc(0, 0, 0, 1, 1, 0);
    check("saturated_tally", int'(exp_cnt), 255);

    // reset mid-run
    cyc(0, 1, 0, 1, 0, 9);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0);
    check("pre_rst_count", int'(count), 4);
    cyc(1, 0, 0, 1, 0, 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_tally", int'(exp_cnt), 0);

    // randomized traffic against the model
    begin
      bit per = 0;
      for (int i = 0; i < 3000; i++) begin
        int ld;
        if ((i % 60) == 0) per = bit'($urandom_range(0, 1));
        ld = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
        cyc($urandom_range(0, 299) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0,
            per, ld);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
